input_debounce: RTL and testbench



---
 rtl/input_debounce_if.sv | 18 +
 rtl/input_debounce.sv | 71 +++++++
 tb/tb_input_debounce.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/input_debounce_if.sv
// input_debounce_if: raw board inputs toward the debouncer and the clean levels and pulses it returns
interface input_debounce_if;
    logic [4:0] btn_raw;
    logic [7:0] sw_raw;
    logic [4:0] btn_db;
    logic [7:0] sw_db;
    logic [4:0] btn_press;
    logic [4:0] btn_release;
    logic [7:0] sw_change;
    modport master (
        output btn_raw, sw_raw,
        input  btn_db, sw_db, btn_press, btn_release, sw_change
    );
    modport slave (
        input  btn_raw, sw_raw,
        output btn_db, sw_db, btn_press, btn_release, sw_change
    );
endinterface

// File: rtl/input_debounce.sv
// input_debounce: per-bit synchronizer, stability counter and edge-pulse generator for 5 buttons and 8 switches
module input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 12500,
    parameter bit BTN_ACTIVE_LOW  = 1'b0,
    parameter bit SW_ACTIVE_LOW   = 1'b0
) (
    input logic clk,
    input logic rst_n,
    input_debounce_if.slave bus
);
    localparam int N  = 13;
    localparam int CW = DEBOUNCE_CYCLES < 2 ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    logic [N-1:0] raw, pre, stable, stable_nx;
    logic [SYNC_STAGES-2:0][N-1:0] chain;
    logic [4:0] press, release_q;
    logic [7:0] sw_chg;
    assign raw = {bus.sw_raw ^ {8{SW_ACTIVE_LOW}}, bus.btn_raw ^ {5{BTN_ACTIVE_LOW}}};
    assign pre = chain[SYNC_STAGES-2];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain[0] <= raw;
            for (int k = 1; k < SYNC_STAGES - 1; k++) chain[k] <= chain[k-1];
        end
    end
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // the stable register doubles as the last synchronizer stage
            assign stable_nx = pre;
        end else begin : g_count
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [N-1:0] sync, hit;
            logic [N-1:0][CW-1:0] cnt;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync <= '0;
                    cnt  <= '0;
                end else begin
                    sync <= pre;
                    for (int i = 0; i < N; i++)
                        cnt[i] <= (sync[i] == stable[i] || cnt[i] == LAST) ? '0 : cnt[i] + 1'b1;
                end
            end
            always_comb begin
                hit = '0;
                for (int i = 0; i < N; i++) hit[i] = cnt[i] == LAST;
            end
            assign stable_nx = stable ^ ((sync ^ stable) & hit);
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable    <= '0;
            press     <= '0;
            release_q <= '0;
            sw_chg    <= '0;
        end else begin
            stable    <= stable_nx;
            press     <= stable_nx[4:0] & ~stable[4:0];
            release_q <= ~stable_nx[4:0] & stable[4:0];
            sw_chg    <= stable_nx[12:5] ^ stable[12:5];
        end
    end
    assign bus.btn_db      = stable[4:0];
    assign bus.sw_db       = stable[12:5];
    assign bus.btn_press   = press;
    assign bus.btn_release = release_q;
    assign bus.sw_change   = sw_chg;
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: four parameterisations driven together, checked against a sample-window model every cycle
module tb_input_debounce;
    localparam int NI = 4;
    localparam int SP [NI] = '{2, 2, 2, 3};
    localparam int DP [NI] = '{4, 4, 0, 5};
    localparam bit BAL [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit SAL [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic [7:0] sw = '0;
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    logic [12:0] hist [NI][32];
    logic [12:0] m_st [NI];
    logic [12:0] m_chg [NI];
    logic [31:0] seen;
    input_debounce_if ifa(), ifb(), ifc(), ifd();
    assign ifa.btn_raw = btn;
    assign ifa.sw_raw  = sw;
    assign ifb.btn_raw = btn;
    assign ifb.sw_raw  = sw;
    assign ifc.btn_raw = btn;
    assign ifc.sw_raw  = sw;
    assign ifd.btn_raw = btn;
    assign ifd.sw_raw  = sw;
    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b0), .SW_ACTIVE_LOW(1'b0))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1), .SW_ACTIVE_LOW(1'b1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    input_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .BTN_ACTIVE_LOW(1'b0), .SW_ACTIVE_LOW(1'b0))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    input_debounce #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(5), .BTN_ACTIVE_LOW(1'b0), .SW_ACTIVE_LOW(1'b1))
        u_d (.clk(clk), .rst_n(rst_n), .bus(ifd));
    always #5 clk = ~clk;

    function automatic logic [30:0] dut_out(int n);
        case (n)
            0: return {ifa.btn_db, ifa.sw_db, ifa.btn_press, ifa.btn_release, ifa.sw_change};
            1: return {ifb.btn_db, ifb.sw_db, ifb.btn_press, ifb.btn_release, ifb.sw_change};
            2: return {ifc.btn_db, ifc.sw_db, ifc.btn_press, ifc.btn_release, ifc.sw_change};
            default: return {ifd.btn_db, ifd.sw_db, ifd.btn_press, ifd.btn_release, ifd.sw_change};
        endcase
    endfunction

    function automatic logic [30:0] model_out(int n);
        logic [12:0] s, c;
        s = m_st[n];
        c = m_chg[n];
        return {s[4:0], s[12:5], c[4:0] & s[4:0], c[4:0] & ~s[4:0], c[12:5]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    // A bit is accepted once the last DP synchronized samples all disagree with the current level.
    initial forever begin
        @(posedge clk);
        for (int n = 0; n < NI; n++) begin
            logic [12:0] r, nx;
            int agree;
            r = {sw ^ {8{SAL[n]}}, btn ^ {5{BAL[n]}}};
            if (!rst_n) begin
                for (int a = 0; a < 32; a++) hist[n][a] = '0;
                m_st[n]  = '0;
                m_chg[n] = '0;
            end else begin
                for (int a = 31; a > 0; a--) hist[n][a] = hist[n][a-1];
                hist[n][0] = r;
                nx = m_st[n];
                for (int b = 0; b < 13; b++) begin
                    if (DP[n] == 0) begin
                        nx[b] = hist[n][SP[n]-1][b];
                    end else begin
                        agree = 0;
                        for (int a = SP[n]; a < SP[n] + DP[n]; a++)
                            if (hist[n][a][b] != m_st[n][b]) agree++;
                        if (agree == DP[n]) nx[b] = ~m_st[n][b];
                    end
                end
                m_chg[n] = nx ^ m_st[n];
                m_st[n]  = nx;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (started)
            for (int n = 0; n < NI; n++)
                chk($sformatf("model_inst%0d", n), {1'b0, dut_out(n)}, {1'b0, model_out(n)});
    end

    initial begin
        tick();
        started = 1'b1;
        chk("reset_a", dut_out(0), 0);
        chk("reset_b", dut_out(1), 0);
        chk("reset_c", dut_out(2), 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        btn = 5'h01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("press_early", ifa.btn_db, 0);
            if (k == 6) chk("press_edge", {ifa.btn_db, ifa.btn_press, ifa.btn_release}, {5'h01, 5'h01, 5'h00});
            if (k == 7) chk("press_width", {ifa.btn_press, ifa.btn_release}, 0);
        end
        btn = 5'h00;
        tick(10);
        sw = 8'h08;
        tick(3);
        sw = 8'h00;
        seen = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            seen = seen | {16'h0, ifa.sw_db, ifa.sw_change};
        end
        chk("glitch3_ignored", seen, 0);
        sw = 8'h08;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) sw = 8'h00;
            if (k == 6) chk("pulse4_accept", {ifa.sw_db, ifa.sw_change}, {8'h08, 8'h08});
            if (k == 10) chk("pulse4_release", {ifa.sw_db, ifa.sw_change}, {8'h00, 8'h08});
        end
        tick(4);
        btn = 5'h1F;
        sw = 8'hA5;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) chk("simul_early", {ifa.btn_press, ifa.sw_change}, 0);
            if (k == 6) chk("simul_edge", {ifa.btn_db, ifa.sw_db, ifa.btn_press, ifa.sw_change},
                            {5'h1F, 8'hA5, 5'h1F, 8'hA5});
            if (k == 7) chk("simul_width", {ifa.btn_press, ifa.sw_change}, 0);
        end
        btn = 5'h00;
        sw = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) chk("simul_release", {ifa.btn_release, ifa.sw_change, ifa.btn_db, ifa.sw_db},
                            {5'h1F, 8'hA5, 5'h00, 8'h00});
        end
        tick(4);
        btn = 5'h04;
        tick(5);
        rst_n = 1'b0;
        tick();
        chk("mid_reset", dut_out(0), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) chk("after_reset_early", ifa.btn_db, 0);
            if (k == 6) chk("after_reset_press", {ifa.btn_db, ifa.btn_press}, {5'h04, 5'h04});
        end
        btn = 5'h00;
        tick(10);
        btn = 5'h1F;
        sw = 8'hFF;
        tick(3);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        seen = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            seen = seen | {17'h0, ifb.btn_db, ifb.btn_press, ifb.btn_release};
        end
        chk("active_low_quiet", seen, 0);
        btn = 5'h0F;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5) chk("active_low_early", ifb.btn_db, 0);
            if (k == 6) chk("active_low_press", {ifb.btn_db, ifb.btn_press}, {5'h10, 5'h10});
        end
        btn = 5'h00;
        sw = 8'h00;
        tick(10);
        for (int t = 1; t <= 16; t++) begin
            sw[0] = 1'(t & 1);
            tick();
            if (t >= 2) chk($sformatf("bypass_t%0d", t), {ifc.sw_db[0], ifc.sw_change[0]}, {1'((t - 1) & 1), 1'b1});
        end
        sw = 8'h00;
        tick(5);
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            btn = btn ^ (5'($urandom) & 5'($urandom));
            sw = sw ^ (8'($urandom) & 8'($urandom));
            tick($urandom_range(1, 10));
        end
        tick(12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
